// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and defaults for the pipeline stall sequencer.
// Holds the FSM state encoding and the per-register control bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam int WAIT_LIMIT_DEF   = 15;
    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int CNT_W_DEF        = 8;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
        logic flush;
        logic bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_DEF = '{
        pc: 1'b1, ifid: 1'b1, idex: 1'b1,
        exmem: 1'b1, memwb: 1'b1,
        flush: 1'b0, bubble: 1'b0
    };

    localparam ctrl_t CTRL_FREEZE = '{
        pc: 1'b0, ifid: 1'b0, idex: 1'b0,
        exmem: 1'b0, memwb: 1'b0,
        flush: 1'b0, bubble: 1'b0
    };

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard inputs from the pipeline and the
// register enable / flush controls returned to it.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       id_rs1;
    logic [2:0]       id_rs2;
    logic             id_useRs1;
    logic             id_useRs2;
    logic [2:0]       ex_dest;
    logic             ex_memRead;
    logic             ex_branchTaken;
    logic             mem_memAccess;
    logic             mem_ready;
    logic             halt_req;
    logic             pc_enb;
    logic             ifid_enb;
    logic             idex_enb;
    logic             exmem_enb;
    logic             memwb_enb;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_useRs1, id_useRs2,
        output ex_dest, ex_memRead, ex_branchTaken,
        output mem_memAccess, mem_ready, halt_req,
        input  pc_enb, ifid_enb, idex_enb, exmem_enb, memwb_enb,
        input  ifid_flush, idex_bubble, halted,
        input  mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_useRs1, id_useRs2,
        input  ex_dest, ex_memRead, ex_branchTaken,
        input  mem_memAccess, mem_ready, halt_req,
        output pc_enb, ifid_enb, idex_enb, exmem_enb, memwb_enb,
        output ifid_flush, idex_bubble, halted,
        output mem_timeout, stall_cycles
    );

endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// load_use_detect: flags an ID-stage source that reads the register
// being loaded by the instruction currently in EX.
module load_use_detect (
    input  logic [2:0] id_rs1,
    input  logic [2:0] id_rs2,
    input  logic       id_useRs1,
    input  logic       id_useRs2,
    input  logic [2:0] ex_dest,
    input  logic       ex_memRead,
    output logic       load_use
);

    logic hit1;
    logic hit2;

    assign hit1     = id_useRs1 & (id_rs1 == ex_dest);
    assign hit2     = id_useRs2 & (id_rs2 == ex_dest);
    assign load_use = ex_memRead & (hit1 | hit2);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: prioritised freeze/flush/bubble sequencer for the
// 5-stage pipeline, with halt-and-drain, memory timeout and stall counter.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT   = WAIT_LIMIT_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int WW = $clog2(WAIT_LIMIT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             tmo_q;
    logic [CNT_W-1:0] cnt_q;

    logic   load_use;
    logic   mstall;
    ctrl_t  ctrl;
    ctrl_t  run_c;
    state_t run_n;
    logic   halt_o;

    load_use_detect u_lud (
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_useRs1  (bus.id_useRs1),
        .id_useRs2  (bus.id_useRs2),
        .ex_dest    (bus.ex_dest),
        .ex_memRead (bus.ex_memRead),
        .load_use   (load_use)
    );

    assign mstall = bus.mem_memAccess & ~bus.mem_ready;

    // Rules shared by RUN and the MEM_WAIT release cycle
    always_comb begin
        run_c = CTRL_DEF;
        run_n = RUN;
        if (bus.ex_branchTaken) begin
            run_c.flush  = 1'b1;
            run_c.bubble = 1'b1;
        end else if (load_use) begin
            run_c.pc     = 1'b0;
            run_c.ifid   = 1'b0;
            run_c.bubble = 1'b1;
        end else if (bus.halt_req) begin
            run_c.pc    = 1'b0;
            run_c.flush = 1'b1;
            run_n       = DRAIN;
        end
    end

    always_comb begin
        ctrl    = CTRL_DEF;
        halt_o  = 1'b0;
        state_d = state_q;
        wait_d  = wait_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (mstall) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = MEM_WAIT;
                    wait_d  = WW'(1);
                end else begin
                    ctrl    = run_c;
                    state_d = run_n;
                    if (run_n == DRAIN) drain_d = DW'(1);
                end
            end
            MEM_WAIT: begin
                if (mstall) begin
                    ctrl = CTRL_FREEZE;
                    if (wait_q != WW'(WAIT_LIMIT)) wait_d = wait_q + WW'(1);
                end else begin
                    ctrl    = run_c;
                    state_d = run_n;
                    wait_d  = '0;
                    if (run_n == DRAIN) drain_d = DW'(1);
                end
            end
            DRAIN: begin
                ctrl.pc    = 1'b0;
                ctrl.flush = 1'b1;
                if (mstall) begin
                    ctrl       = CTRL_FREEZE;
                    ctrl.flush = 1'b1;
                end else if (bus.ex_branchTaken) begin
                    ctrl.pc     = 1'b1;
                    ctrl.bubble = 1'b1;
                end
                if (!bus.halt_req) begin
                    state_d = RUN;
                    drain_d = '0;
                end else if (!mstall) begin
                    if (drain_q == DW'(DRAIN_CYCLES)) begin
                        state_d = HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
            end
            HALTED: begin
                ctrl   = CTRL_FREEZE;
                halt_o = 1'b1;
                if (!bus.halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (!rst) begin
            ctrl   = CTRL_DEF;
            halt_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            drain_q <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            if (state_d == MEM_WAIT && int'(wait_d) >= WAIT_LIMIT)
                tmo_q <= 1'b1;
            if ((state_q == RUN || state_q == MEM_WAIT) && !ctrl.pc &&
                cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_enb       = ctrl.pc;
    assign bus.ifid_enb     = ctrl.ifid;
    assign bus.idex_enb     = ctrl.idex;
    assign bus.exmem_enb    = ctrl.exmem;
    assign bus.memwb_enb    = ctrl.memwb;
    assign bus.ifid_flush   = ctrl.flush;
    assign bus.idex_bubble  = ctrl.bubble;
    assign bus.halted       = halt_o;
    assign bus.mem_timeout  = tmo_q;
    assign bus.stall_cycles = cnt_q;

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central hazard and stall sequencer for the 5-stage 8-bit pipeline. It drives the enable and flush/bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three events by priority: data-memory wait, taken branch and load-use. It also supports a halt-and-drain request and exposes a memory-timeout flag and a stall-cycle counter.

## Interface
Parameters:
- WAIT_LIMIT, 15: max consecutive MEM_WAIT cycles before timeout.
- DRAIN_CYCLES, 4: bubble cycles injected before HALTED.
- CNT_W, 8: stall counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- id_rs1, id_rs2  in  3 each  source registers of the instruction in ID.
- id_useRs1, id_useRs2  in  1 each  source actually read.
- ex_dest  in  3  destination register of the instruction in EX.
- ex_memRead  in  1  instruction in EX is a load.
- ex_branchTaken  in  1  branch in EX resolved taken.
- mem_memAccess  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes access this cycle.
- halt_req  in  1  level request to drain and stop.
- pc_enb, ifid_enb, idex_enb, exmem_enb, memwb_enb  out  1 each  register enables.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads zero control.
- halted  out  1  in HALTED.
- mem_timeout  out  1  sticky wait-limit error.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_enb=0 in RUN/MEM_WAIT.

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED. Control outputs are combinational (Mealy) from state and inputs. State and counters are registered.
- Default outputs: all enb=1, ifid_flush=0, idex_bubble=0.
- Load-use condition: `load_use = ex_memRead & ((id_useRs1 & id_rs1==ex_dest) | (id_useRs2 & id_rs2==ex_dest))`.
- Memory-stall condition: `mstall = mem_memAccess & ~mem_ready`.
- RUN, first matching rule applies:
  1. mstall: all five enb=0 (full freeze; repeated WB writes are idempotent). Next state MEM_WAIT, wait_cnt<=1.
  2. ex_branchTaken: ifid_flush=1, idex_bubble=1, pc_enb=1.
  3. load_use: pc_enb=0, ifid_enb=0, idex_bubble=1.
  4. halt_req: pc_enb=0, ifid_flush=1. Next state DRAIN, drain_cnt<=1.
  5. Otherwise: defaults.
- MEM_WAIT:
  - While mem_ready=0: full freeze and wait_cnt++.
  - If wait_cnt reaches WAIT_LIMIT, set mem_timeout. The state remains MEM_WAIT and frozen.
  - When mem_ready=1: apply RUN rules 2–5 (rule 1 cannot fire) and return to RUN.
- DRAIN:
  - Each cycle: pc_enb=0, ifid_flush=1, drain_cnt++.
  - mstall: full freeze, drain_cnt holds.
  - ex_branchTaken: pc_enb=1 so the target is captured; ifid_flush=1, idex_bubble=1.
  - halt_req=0: RUN next cycle.
  - drain_cnt==DRAIN_CYCLES and no mstall: HALTED next cycle.
- HALTED: all enb=0, halted=1. halt_req=0 gives RUN next cycle.
- mem_timeout is cleared only by reset.
- stall_cycles saturates at 2^CNT_W−1.

## Timing
- Zero-cycle response: a hazard present in cycle n gates that cycle's clock edge.
- Load-use inserts exactly 1 bubble, because the bubble clears ex_memRead in cycle n+1.
- Branch flush discards exactly 2 younger instructions.
- Simultaneous mstall with branch or load-use: the freeze wins. The branch or hazard inputs remain stable while frozen and are acted on in the release cycle.
- Halt latency: halted=1 exactly DRAIN_CYCLES+1 cycles after halt_req rises, provided there is no memory stall.
- Reset (rst=0 at a clock edge): state RUN, wait_cnt=drain_cnt=0, mem_timeout=0, stall_cycles=0.
- While rst=0, outputs are forced to defaults with halted=0, regardless of other inputs.
- Reset mid-wait or mid-drain aborts immediately.

## Structure
- Shared package pipe_ctrl_pkg holds the state enum (2-bit) and the default DRAIN_CYCLES/WAIT_LIMIT constants.
- Sub-module load_use_detect is combinational: register compare producing load_use.
- The remainder is one FSM with its counters.

## Test plan
- ex_memRead=1, ex_dest=3, id_rs2=3, id_useRs2=1 -> one cycle of pc_enb=0, ifid_enb=0, idex_bubble=1, then defaults; stall_cycles=1.
- ex_branchTaken=1 for 1 cycle -> ifid_flush=1, idex_bubble=1, pc_enb=1; state stays RUN.
- mem_memAccess=1, mem_ready=0 for 3 cycles then 1 -> all enb=0 for 3 cycles, enb=1 in the 4th; stall_cycles=3; mem_timeout=0.
- mem_ready held 0 for 20 cycles with WAIT_LIMIT=15 -> mem_timeout rises after wait_cnt reaches 15 and stays 1 until rst=0.
- halt_req=1 steady -> 5 cycles of pc_enb=0, ifid_flush=1, then halted=1 with all enb=0; drop halt_req -> RUN next cycle.
- mstall coincident with ex_branchTaken and load_use -> full freeze; on mem_ready=1 the branch flush (not the load-use stall) is applied.
